// File: rtl/sample_packet_buffer.sv
// Sample packet buffer: single-clock FIFO between the ADC conversion stage and the
// USB read logic. It raises packet_ready_o once a full transfer packet is buffered,
// can substitute a deterministic ramp for the live samples, and keeps a sticky
// overflow flag so the host can detect dropped samples.
//
// Ports:
//   inclk_i            sample clock, all logic on the rising edge
//   reset_i            asynchronous, active-high reset
//   collect_data_i     capture enable; low flushes the buffer on the next edge
//   test_mode_i        select ramp pattern, latched on entry to capture
//   sample_data_i      signed 16-bit sample, qualified by sample_valid_i
//   read_request_i     pop one word (ignored while empty)
//   read_data_o        popped word, valid with read_data_valid_o one cycle later
//   packet_ready_o     occupancy >= PACKET_WORDS
//   buffer_overflow_o  sticky drop indicator, cleared by dropping collect_data_i
//   word_count_o       current occupancy
module sample_packet_buffer #(
  parameter int unsigned DEPTH_LOG2   = 14,
  parameter int unsigned PACKET_WORDS = 8192
) (
  input  logic                  inclk_i,
  input  logic                  reset_i,
  input  logic                  collect_data_i,
  input  logic                  test_mode_i,
  input  logic [15:0]           sample_data_i,
  input  logic                  sample_valid_i,
  input  logic                  read_request_i,
  output logic [15:0]           read_data_o,
  output logic                  read_data_valid_o,
  output logic                  packet_ready_o,
  output logic                  buffer_overflow_o,
  output logic [DEPTH_LOG2:0]   word_count_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   PktWords = PACKET_WORDS[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   CountOne = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PtrOne   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StCapture, StHalted} state_e;

  state_e                state_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [9:0]            pat_cnt_q;
  logic                  test_mode_q;
  logic [15:0]           read_data_q;
  logic                  read_valid_q;
  logic                  packet_ready_q;
  logic                  overflow_q;
  logic [15:0]           mem_q [Depth];

  logic                  rd_en, wr_en, drop, sample_in;
  logic [15:0]           wr_data;

  always_comb begin
    rd_en     = collect_data_i && read_request_i && (count_q != '0) && (state_q != StIdle);
    sample_in = collect_data_i && sample_valid_i && (state_q == StCapture);
    // Occupancy == Depth exactly when the top count bit is set.
    wr_en     = sample_in && (!count_q[DEPTH_LOG2] || rd_en);
    drop      = sample_in && count_q[DEPTH_LOG2] && !rd_en;
    count_d   = count_q;
    if (wr_en && !rd_en) begin
      count_d = count_q + CountOne;
    end else if (rd_en && !wr_en) begin
      count_d = count_q - CountOne;
    end
    // Ramp in the conversion stage's offset-binary-to-signed format.
    wr_data = test_mode_q ? {~pat_cnt_q[9], pat_cnt_q[8:0], 6'b0} : sample_data_i;
  end

  always_ff @(posedge inclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pat_cnt_q      <= '0;
      test_mode_q    <= 1'b0;
      read_data_q    <= '0;
      read_valid_q   <= 1'b0;
      packet_ready_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else if (!collect_data_i) begin
      // Flush; read_data_q deliberately keeps its last value.
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      pat_cnt_q      <= '0;
      read_valid_q   <= 1'b0;
      packet_ready_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      read_valid_q   <= rd_en;
      count_q        <= count_d;
      packet_ready_q <= (count_d >= PktWords);
      if (rd_en) begin
        read_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + PtrOne;
      end
      if (wr_en) begin
        wr_ptr_q  <= wr_ptr_q + PtrOne;
        pat_cnt_q <= pat_cnt_q + 10'd1;
      end
      unique case (state_q)
        StIdle: begin
          state_q     <= StCapture;
          test_mode_q <= test_mode_i;
          pat_cnt_q   <= '0;
        end
        StCapture: begin
          if (drop) begin
            state_q    <= StHalted;
            overflow_q <= 1'b1;
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage has no reset; only occupancy and pointers give it meaning.
  always_ff @(posedge inclk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign read_data_o       = read_data_q;
  assign read_data_valid_o = read_valid_q;
  assign packet_ready_o    = packet_ready_q;
  assign buffer_overflow_o = overflow_q;
  assign word_count_o      = count_q;

endmodule

// File: tb/tb_sample_packet_buffer.sv
module tb_sample_packet_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, col, tm, val, rr;
  logic [15:0] din;

  logic [15:0] b_rd, s_rd;
  logic        b_rdv, b_pr, b_ovf, s_rdv, s_pr, s_ovf;
  logic [14:0] b_wc;
  logic [4:0]  s_wc;

  // Big instance uses default sizing, small one is 16 deep with 8-word packets.
  sample_packet_buffer u_big (
    .inclk_i(clk), .reset_i(rst), .collect_data_i(col & ~sel), .test_mode_i(tm),
    .sample_data_i(din), .sample_valid_i(val), .read_request_i(rr),
    .read_data_o(b_rd), .read_data_valid_o(b_rdv), .packet_ready_o(b_pr),
    .buffer_overflow_o(b_ovf), .word_count_o(b_wc)
  );

  sample_packet_buffer #(.DEPTH_LOG2(4), .PACKET_WORDS(8)) u_small (
    .inclk_i(clk), .reset_i(rst), .collect_data_i(col & sel), .test_mode_i(tm),
    .sample_data_i(din), .sample_valid_i(val), .read_request_i(rr),
    .read_data_o(s_rd), .read_data_valid_o(s_rdv), .packet_ready_o(s_pr),
    .buffer_overflow_o(s_ovf), .word_count_o(s_wc)
  );

  logic [15:0] rd;
  logic        rdv, pr, ovf;
  logic [14:0] wc;
  assign rd  = sel ? s_rd  : b_rd;
  assign rdv = sel ? s_rdv : b_rdv;
  assign pr  = sel ? s_pr  : b_pr;
  assign ovf = sel ? s_ovf : b_ovf;
  assign wc  = sel ? {10'b0, s_wc} : b_wc;

  int tests = 0;
  int fails = 0;

  // Reference model: a queue plus a few flags.
  logic [15:0] m_q[$];
  logic [15:0] m_rdata[2];
  bit          m_cap, m_halt, m_ovf, m_tm, m_rdv;
  int          m_c;

  function automatic logic [15:0] ramp(int c);
    int v;
    v = (c - 512) * 64;
    return v[15:0];
  endfunction

  function automatic logic [33:0] obs();
    return {rdv, rd, pr, ovf, wc};
  endfunction

  function automatic logic [33:0] model_exp();
    int pw;
    pw = sel ? 8 : 8192;
    return {m_rdv, m_rdata[sel], (m_q.size() >= pw), m_ovf, 15'(m_q.size())};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    m_cap = 0; m_halt = 0; m_ovf = 0; m_tm = 0; m_rdv = 0; m_c = 0;
  endtask

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick(input bit c, input bit t, input bit v, input logic [15:0] d,
                      input bit r);
    int depth;
    depth = sel ? 16 : 16384;
    col = c; tm = t; val = v; din = d; rr = r;
    @(posedge clk);
    if (!c) begin
      m_q.delete();
      m_cap = 0; m_halt = 0; m_ovf = 0; m_rdv = 0; m_c = 0;
    end else if (!m_cap) begin
      m_cap = 1; m_tm = t; m_c = 0; m_rdv = 0;
    end else begin
      m_rdv = r && (m_q.size() > 0);
      if (m_rdv) m_rdata[sel] = m_q.pop_front();
      if (v && !m_halt) begin
        if (m_q.size() < depth) begin
          m_q.push_back(m_tm ? ramp(m_c) : d);
          m_c = (m_c + 1) % 1024;
        end else begin
          m_ovf = 1;
          m_halt = 1;
        end
      end
    end
    #1;
  endtask

  task automatic stepc(input bit c, input bit t, input bit v, input logic [15:0] d,
                       input bit r, input string name);
    tick(c, t, v, d, r);
    chk(name, obs(), model_exp());
  endtask

  task automatic switch_to(input logic s);
    sel = s;
    stepc(0, 0, 0, 16'h0, 0, "flush");
  endtask

  typedef struct {
    bit          c, v, r;
    logic [15:0] d;
    bit          e_rdv;
    logic [15:0] e_rd;
    int          e_wc;
  } vec_t;

  vec_t        vecs[9];
  logic [15:0] ins[16];
  logic [15:0] popped[$];

  initial begin
    rst = 1'b1; sel = 1'b0; col = 0; tm = 0; val = 0; rr = 0; din = '0;
    model_reset();
    #3;
    chk("reset_state_big", obs(), 34'h0);
    sel = 1'b1;
    #1;
    chk("reset_state_small", obs(), 34'h0);
    #4;
    rst = 1'b0;

    // Table-driven basic sequence on the small buffer.
    vecs[0] = '{1, 1, 0, 16'hAAAA, 0, 16'h0000, 0};
    vecs[1] = '{1, 1, 0, 16'h1111, 0, 16'h0000, 1};
    vecs[2] = '{1, 1, 0, 16'h2222, 0, 16'h0000, 2};
    vecs[3] = '{1, 0, 1, 16'h0000, 1, 16'h1111, 1};
    vecs[4] = '{1, 1, 1, 16'h3333, 1, 16'h2222, 1};
    vecs[5] = '{1, 0, 1, 16'h0000, 1, 16'h3333, 0};
    vecs[6] = '{1, 0, 1, 16'h0000, 0, 16'h3333, 0};
    vecs[7] = '{1, 1, 1, 16'h4444, 0, 16'h3333, 1};
    vecs[8] = '{0, 0, 1, 16'h0000, 0, 16'h3333, 0};
    switch_to(1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(vecs[i].c, 0, vecs[i].v, vecs[i].d, vecs[i].r);
      chk($sformatf("vec%0d", i), obs(),
          {vecs[i].e_rdv, vecs[i].e_rd, 1'b0, 1'b0, 15'(vecs[i].e_wc)});
    end

    // Test pattern on the big buffer: 1030 ramp words, then drain.
    switch_to(1'b0);
    stepc(1, 1, 0, 16'h0, 0, "tp_enter");
    for (int i = 0; i < 1030; i++) stepc(1, 1, 1, 16'(i), 0, "tp_fill");
    chk("tp_count", {19'b0, wc}, 34'd1030);
    for (int i = 0; i < 1032; i++) begin
      stepc(1, 1, 0, 16'h0, 1, "tp_drain");
      if (rdv) popped.push_back(rd);
    end
    chk("tp_popped", 34'(popped.size()), 34'd1030);
    if (popped.size() == 1030) begin
      chk("tp_w0", {18'b0, popped[0]}, 34'h8000);
      chk("tp_w1", {18'b0, popped[1]}, 34'h8040);
      chk("tp_w512", {18'b0, popped[512]}, 34'h0000);
      chk("tp_w1023", {18'b0, popped[1023]}, 34'h7FC0);
      chk("tp_w1024", {18'b0, popped[1024]}, 34'h8000);
    end

    // Packet threshold.
    switch_to(1'b0);
    stepc(1, 0, 0, 16'h0, 0, "pk_enter");
    for (int i = 0; i < 8191; i++) stepc(1, 0, 1, 16'($urandom), 0, "pk_fill");
    chk("pk_8191", {18'b0, pr, wc}, {18'b0, 1'b0, 15'd8191});
    stepc(1, 0, 1, 16'h1234, 0, "pk_last");
    chk("pk_8192", {18'b0, pr, wc}, {18'b0, 1'b1, 15'd8192});
    stepc(1, 0, 0, 16'h0, 1, "pk_read");
    chk("pk_read_back", {18'b0, pr, wc}, {18'b0, 1'b0, 15'd8191});

    // Overflow on the small buffer.
    switch_to(1'b1);
    stepc(1, 0, 0, 16'h0, 0, "ov_enter");
    for (int i = 0; i < 16; i++) begin
      ins[i] = 16'($urandom);
      stepc(1, 0, 1, ins[i], 0, "ov_fill");
    end
    chk("ov_full", {18'b0, ovf, wc}, {18'b0, 1'b0, 15'd16});
    stepc(1, 0, 1, 16'hDEAD, 0, "ov_17th");
    chk("ov_set", {18'b0, ovf, wc}, {18'b0, 1'b1, 15'd16});
    for (int i = 0; i < 16; i++) begin
      stepc(1, 0, 1, 16'hBEEF, 1, "ov_drain");
      chk("ov_drain_word", {16'b0, rdv, ovf, rd}, {16'b0, 1'b1, 1'b1, ins[i]});
    end
    chk("ov_empty", {18'b0, ovf, wc}, {18'b0, 1'b1, 15'd0});
    stepc(0, 0, 0, 16'h0, 0, "ov_clear");
    chk("ov_cleared", {33'b0, ovf}, 34'd0);

    // Full with simultaneous read and write.
    stepc(1, 0, 0, 16'h0, 0, "fs_enter");
    for (int i = 0; i < 16; i++) begin
      ins[i] = 16'($urandom);
      stepc(1, 0, 1, ins[i], 0, "fs_fill");
    end
    stepc(1, 0, 1, 16'h5A5A, 1, "fs_both");
    chk("fs_result", {rdv, rd, ovf, wc}, {1'b1, ins[0], 1'b0, 15'd16});

    // Read while empty.
    switch_to(1'b1);
    stepc(1, 0, 0, 16'h0, 0, "re_enter");
    for (int i = 0; i < 3; i++) begin
      stepc(1, 0, 0, 16'h0, 1, "re_read");
      chk("re_empty", {18'b0, rdv, wc}, 34'd0);
    end

    // Asynchronous reset mid-capture.
    switch_to(1'b0);
    stepc(1, 0, 0, 16'h0, 0, "ar_enter");
    for (int i = 0; i < 100; i++) stepc(1, 0, 1, 16'($urandom), i[0], "ar_fill");
    for (int i = 0; i < 60; i++) stepc(1, 0, 1, 16'($urandom), 0, "ar_fill2");
    #2;
    rst = 1'b1;
    col = 1'b0;
    #1;
    chk("ar_immediate", obs(), 34'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    stepc(0, 0, 0, 16'h0, 0, "ar_flush");

    // collectData drop mid-capture, then ramp restart.
    stepc(1, 1, 0, 16'h0, 0, "cd_enter");
    for (int i = 0; i < 100; i++) stepc(1, 1, 1, 16'h0, 0, "cd_fill");
    chk("cd_100", {19'b0, wc}, 34'd100);
    stepc(0, 1, 1, 16'h0, 1, "cd_drop");
    chk("cd_cleared", {18'b0, pr, wc}, 34'd0);
    stepc(1, 1, 0, 16'h0, 0, "cd_reenter");
    for (int i = 0; i < 3; i++) stepc(1, 1, 1, 16'h0, 0, "cd_refill");
    stepc(1, 1, 0, 16'h0, 1, "cd_pop0");
    chk("cd_first", {17'b0, rdv, rd}, {17'b0, 1'b1, 16'h8000});
    stepc(1, 1, 0, 16'h0, 1, "cd_pop1");
    chk("cd_second", {17'b0, rdv, rd}, {17'b0, 1'b1, 16'h8040});

    // Randomised traffic on the small buffer against the model.
    switch_to(1'b1);
    for (int i = 0; i < 3000; i++) begin
      bit c, t, v, r;
      c = ($urandom_range(0, 79) != 0);
      t = $urandom_range(0, 1) == 1;
      v = $urandom_range(0, 3) != 0;
      r = (i % 1000 < 500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      stepc(c, t, v, 16'($urandom), r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
